fds_bus_master: RTL and testbench
=================================

Name: fds_bus_master

Overview:
- CPU-side initiator for the FDS audio register interface; the bus master that `fds_audio` responds to.
- Accepts queued register read/write requests via a valid/ready handshake and buffers them in a small FIFO.
- Replays each request as exactly one M2-aligned bus cycle (`wr`/`addr`/`data`) and returns read data captured from the responder's `data_out`.
- Used by the NSF/test-player path and by the debug register poker to drive FDS audio without the 6502 core.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2)
- IDLE_ADDR, 16'h0000, address driven when no transaction is active

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- m2  in  1  NES M2 phase, same signal fed to `fds_audio`
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  register address
- req_data  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-clk pulse, read data valid
- rsp_data  out  8  captured read data
- bus_wr  out  1  to `fds_audio` `wr`
- bus_addr  out  16  to `fds_audio` `addr_in`
- bus_wdata  out  8  to `fds_audio` `data_in`
- bus_rdata  in  8  from `fds_audio` `data_out` (combinational there)
- busy  out  1  FIFO non-empty or transaction in flight

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All outputs registered.
- Reset values: bus_wr=0, bus_addr=IDLE_ADDR, bus_wdata=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=0 during reset then 1. FIFO emptied.
- m2_q is m2 registered on clk; m2_rise = m2 & ~m2_q, matching the responder's edge detect.
- Enqueue when req_valid & req_ready. req_ready = !full. Enqueue while full is ignored.
- Simultaneous enqueue and pop on a full FIFO is legal only via pop-first ordering: pop frees the slot, but req_ready is still computed from pre-pop full, so no enqueue that cycle.
- States:
  - IDLE: if FIFO non-empty & ~m2 & ~m2_q → pop, load bus_addr/bus_wdata, bus_wr=req_write; go DRIVE.
  - DRIVE: hold bus_addr, bus_wdata and bus_wr stable. On m2_rise clk: for reads, rsp_data<=bus_rdata and rsp_valid<=1 next clk. Go RELEASE.
  - RELEASE: bus_wr<=0, bus_addr<=IDLE_ADDR; wait until ~m2; go IDLE.
- Transaction rate: at most one transaction per M2 period. Consecutive requests occupy consecutive M2 periods when the FIFO is fed early.
- Read capture timing: the read returns pre-update register state, because sampling happens on the same clk the responder commits. Reads never assert bus_wr.
- m2 stuck high: stay in IDLE, no pop.
- m2 stuck low in DRIVE: hold indefinitely, no timeout.
- Reset mid-transaction: immediately returns to IDLE with bus_wr=0 next clk. Queued and in-flight requests are dropped; no rsp issued.
- busy = FIFO non-empty | state != IDLE.

Decomposition:
- Package `fds_pkg`:
  - Register address constants: FDS_WAVE_BASE=16'h4040, FDS_VOL_ENV=16'h4080, FDS_FREQ_LO/HI=16'h4082/4083, FDS_SWEEP=16'h4084, FDS_MOD_BIAS=16'h4085, FDS_MOD_FREQ_LO/HI=16'h4086/4087, FDS_MOD_TABLE=16'h4088, FDS_MASTER=16'h4089, FDS_ENV_SPEED=16'h408A, FDS_STATUS_BASE=16'h4090.
  - Typedef `fds_req_t` {write, addr[15:0], data[7:0]}.
  - State enum.
- One sub-module: `fds_req_fifo`, a synchronous FIFO of `fds_req_t` with FIFO_DEPTH entries and full/empty flags.

Test Plan:
- Single write {1,16'h4089,8'h80} with m2 toggling every 12 clks → bus_wr=1, addr=4089, wdata=80 held across exactly one m2_rise; bus_wr=0 after m2 falls; `fds_audio` wave_wren=1.
- Wave load: 64 writes 4040..407F, data=index, queued back-to-back → 64 consecutive M2 periods, each with exactly one bus_wr. req_ready deasserts with 4 entries queued. Readback of 4040..407F returns 0..63.
- Read {0,16'h4090} after writing 4080=8'h85 → rsp_valid pulses once, rsp_data=8'h45.
- Mod table: write 4087=8'h80, then 4088=8'h03 ×32 → 32 M2 periods, no dropped write; subsequent 4095 read shows entry value 3 in low bits.
- Request arrives with m2 high → no bus activity until m2 falls, then transaction starts; bus_addr never changes while m2 is high.
- Reset asserted in DRIVE with 3 queued → next clk bus_wr=0, busy=0, no rsp_valid; after reset the FIFO is empty.

Source files
------------

// File: rtl/fds_pkg.sv
// Shared definitions for the FDS audio bus master: register map, request record, FSM states.
package fds_pkg;

  localparam logic [15:0] FDS_WAVE_BASE   = 16'h4040;
  localparam logic [15:0] FDS_VOL_ENV     = 16'h4080;
  localparam logic [15:0] FDS_FREQ_LO     = 16'h4082;
  localparam logic [15:0] FDS_FREQ_HI     = 16'h4083;
  localparam logic [15:0] FDS_SWEEP       = 16'h4084;
  localparam logic [15:0] FDS_MOD_BIAS    = 16'h4085;
  localparam logic [15:0] FDS_MOD_FREQ_LO = 16'h4086;
  localparam logic [15:0] FDS_MOD_FREQ_HI = 16'h4087;
  localparam logic [15:0] FDS_MOD_TABLE   = 16'h4088;
  localparam logic [15:0] FDS_MASTER      = 16'h4089;
  localparam logic [15:0] FDS_ENV_SPEED   = 16'h408A;
  localparam logic [15:0] FDS_STATUS_BASE = 16'h4090;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
  } fds_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RELEASE
  } fds_state_t;

endpackage

// File: rtl/fds_req_fifo.sv
// Show-ahead request FIFO; in_ready/full/empty are registered from the next-cycle fill level.
module fds_req_fifo
  import fds_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  fds_req_t din,
  output fds_req_t dout,
  output logic     in_ready,
  output logic     full,
  output logic     empty,
  output logic     empty_next
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  fds_req_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_nxt;
  logic            do_push;
  logic            do_pop;

  // Push is gated by the pre-pop ready flag, so a full FIFO never accepts even while popping.
  assign do_push = push & in_ready;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + 1'b1;
    else if (do_pop && !do_push)
      level_nxt = level - 1'b1;
  end

  assign empty_next = (level_nxt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      full     <= (level_nxt == LW'(FIFO_DEPTH));
      in_ready <= (level_nxt != LW'(FIFO_DEPTH));
      empty    <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fds_bus_master.sv
// CPU-side initiator for the FDS audio registers: replays queued requests as one
// M2-aligned bus cycle each and returns read data sampled on the responder's commit edge.
module fds_bus_master
  import fds_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m2,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        busy
);

  fds_state_t state;
  fds_req_t   head;
  fds_req_t   req_in;
  logic       m2_q;
  logic       m2_rise;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_empty_next;

  assign req_in    = '{write: req_write, addr: req_addr, data: req_data};
  assign fifo_push = req_valid & req_ready;
  assign m2_rise   = m2 & ~m2_q;
  // Only start while M2 is solidly low so the whole high phase sees a stable address.
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty & ~m2 & ~m2_q;

  fds_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .din        (req_in),
    .dout       (head),
    .in_ready   (req_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  always_ff @(posedge clk) begin
    if (reset) m2_q <= 1'b0;
    else       m2_q <= m2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bus_wr    <= 1'b0;
      bus_addr  <= IDLE_ADDR;
      bus_wdata <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            bus_addr  <= head.addr;
            bus_wdata <= head.data;
            bus_wr    <= head.write;
            busy      <= 1'b1;
            state     <= ST_DRIVE;
          end else begin
            busy <= ~fifo_empty_next;
          end
        end
        ST_DRIVE: begin
          busy <= 1'b1;
          // The responder commits on this same clk, so reads see pre-update state.
          if (m2_rise) begin
            if (!bus_wr) begin
              rsp_data  <= bus_rdata;
              rsp_valid <= 1'b1;
            end
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          bus_wr   <= 1'b0;
          bus_addr <= IDLE_ADDR;
          if (!m2) begin
            busy  <= ~fifo_empty_next;
            state <= ST_IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fds_bus_master.sv
// Scoreboard bench for fds_bus_master with a small register-file responder on the bus.
module tb_fds_bus_master;
  import fds_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wexp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m2 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_data = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  wexp_t      wr_q[$];
  logic [7:0] rsp_q[$];

  logic [7:0]  mem [0:255];
  logic [5:0]  gain = 6'd0;
  logic        m2_q_r = 1'b0;
  logic        commit = 1'b0;
  logic [15:0] c_addr = 16'h0;
  logic [7:0]  c_data = 8'h0;
  int          cyc = 0;
  int          last_commit = -1;
  bit          gap_on = 1'b0;
  bit          saw_full = 1'b0;

  fds_bus_master #(.FIFO_DEPTH(4), .IDLE_ADDR(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .m2        (m2),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (12) @(negedge clk);
      m2 = ~m2;
    end
  end

  // Responder: commits writes on the M2 rising clk; status register reads {01, gain}.
  always_comb begin
    if (bus_addr == FDS_STATUS_BASE) bus_rdata = {2'b01, gain};
    else                             bus_rdata = mem[bus_addr[7:0]];
  end

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m2_q_r <= m2;
    if (m2 && !m2_q_r && bus_wr) begin
      if (bus_addr[15:8] == 8'h40) mem[bus_addr[7:0]] <= bus_wdata;
      if (bus_addr == FDS_VOL_ENV && bus_wdata[7]) gain <= bus_wdata[5:0];
      commit <= 1'b1;
      c_addr <= bus_addr;
      c_data <= bus_wdata;
    end else begin
      commit <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the bus commits a write or a response appears.
  always @(negedge clk) begin
    wexp_t e;
    logic [7:0] r;
    if (commit) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", c_addr, c_data);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(c_addr), 32'(e.a));
        check("wr_data", 32'(c_data), 32'(e.d));
      end
      if (gap_on && last_commit >= 0) check("m2_period_gap", 32'(cyc - last_commit), 32'd24);
      last_commit = cyc;
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got 0x%0h expected none", rsp_data);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(r));
      end
    end
  end

  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input bit exp_on, input logic [7:0] rexp);
    int cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    cnt = 0;
    while (!req_ready && cnt < 3000) begin
      saw_full = 1'b1;
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 3000) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (exp_on) begin
      if (w) wr_q.push_back('{a: a, d: d});
      else   rsp_q.push_back(rexp);
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    repeat (3) @(negedge clk);
    cnt = 0;
    while (busy && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 5000) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    bit moved;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_bus_wr", 32'(bus_wr), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'h0000);
    check("rst_bus_wdata", 32'(bus_wdata), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single master-register write
    send(1'b1, FDS_MASTER, 8'h80, 1'b1, 8'h00);
    release_req();
    wait_idle();
    check("single_wr_done", 32'(wr_q.size()), 32'd0);
    check("single_bus_wr_low", 32'(bus_wr), 32'd0);

    // Wave table load, back-to-back: one write per M2 period
    saw_full = 1'b0;
    last_commit = -1;
    gap_on = 1'b1;
    for (int i = 0; i < 64; i++) send(1'b1, FDS_WAVE_BASE + 16'(i), 8'(i), 1'b1, 8'h00);
    release_req();
    wait_idle();
    gap_on = 1'b0;
    check("wave_saw_full", 32'(saw_full), 32'd1);
    check("wave_all_written", 32'(wr_q.size()), 32'd0);

    // Wave readback
    for (int i = 0; i < 64; i++) send(1'b0, FDS_WAVE_BASE + 16'(i), 8'h00, 1'b1, 8'(i));
    release_req();
    wait_idle();
    check("wave_all_read", 32'(rsp_q.size()), 32'd0);

    // Volume gain write, then status read
    send(1'b1, FDS_VOL_ENV, 8'h85, 1'b1, 8'h00);
    send(1'b0, FDS_STATUS_BASE, 8'h00, 1'b1, 8'h45);
    release_req();
    wait_idle();

    // Mod table: frequency high then 32 table writes, none dropped
    last_commit = -1;
    gap_on = 1'b1;
    send(1'b1, FDS_MOD_FREQ_HI, 8'h80, 1'b1, 8'h00);
    for (int i = 0; i < 32; i++) send(1'b1, FDS_MOD_TABLE, 8'h03, 1'b1, 8'h00);
    release_req();
    wait_idle();
    gap_on = 1'b0;
    check("mod_all_written", 32'(wr_q.size()), 32'd0);

    // Request arriving while M2 is high waits for the low phase
    cnt = 0;
    while (m2 && cnt < 100) begin @(negedge clk); cnt++; end
    while (!m2 && cnt < 100) begin @(negedge clk); cnt++; end
    send(1'b0, FDS_STATUS_BASE, 8'h00, 1'b1, 8'h45);
    release_req();
    moved = 1'b0;
    cnt = 0;
    while (m2 && cnt < 100) begin
      if (bus_wr !== 1'b0 || bus_addr !== 16'h0000) moved = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check("m2_high_no_bus_activity", 32'(moved), 32'd0);
    wait_idle();
    check("m2_high_rsp_seen", 32'(rsp_q.size()), 32'd0);

    // Reset while in DRIVE with three reads still queued: all dropped
    cnt = 0;
    while (m2 && cnt < 100) begin @(negedge clk); cnt++; end
    while (!m2 && cnt < 100) begin @(negedge clk); cnt++; end
    for (int i = 0; i < 4; i++) send(1'b0, FDS_WAVE_BASE + 16'(i), 8'h00, 1'b0, 8'h00);
    release_req();
    cnt = 0;
    while (bus_addr == 16'h0000 && cnt < 100) begin @(negedge clk); cnt++; end
    check("drive_reached", 32'(cnt < 100), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_bus_wr", 32'(bus_wr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bus_addr", 32'(bus_addr), 32'h0000);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_req_ready", 32'(req_ready), 32'd1);

    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
